// File: rtl/spart_fifo.sv
`timescale 1ns/1ps
// spart_fifo: memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor and oversampled RX.
// Bus reads are combinational; pops/writes commit at the edge ending the access; writes to a full TX FIFO are dropped.

module spart_fifo_buf #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic [7:0] push_dat_i,
   input  logic       pop_i,
   output logic [7:0] head_dat_o,
   output logic       empty_o,
   output logic       full_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        push_ok, pop_ok;

   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok     = pop_i && !empty_o;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign push_ok    = push_i && (!full_o || pop_i);
   assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
   assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_ok};

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
endmodule

module spart_fifo #(
   parameter int          FIFO_DEPTH = 8,
   parameter int          OVERSAMPLE = 16,
   parameter logic [15:0] RESET_DIV  = 16'd324
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);
   localparam int            CW        = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] OS_LAST   = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

   logic        bus_rd, bus_wr, div_wr, rx_pop, tx_push, tick;
   logic [7:0]  rd_dat, status, tx_head, rx_head;
   logic        tx_empty, tx_full, rx_empty, rx_full, tx_idle;
   logic [15:0] div_q, div_d, baud_cnt_q, baud_cnt_d;
   logic        ferr_q, ferr_d, ovr_q, ovr_d;

   state_e        tx_state_q, tx_state_d;
   logic [CW-1:0] tx_tcnt_q, tx_tcnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_pop, txd_q, txd_d;

   state_e        rx_state_q, rx_state_d;
   logic [CW-1:0] rx_tcnt_q, rx_tcnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
   logic          rx_push, rx_ferr_set, rx_ovr_set;

   assign bus_rd  = iocs && iorw;
   assign bus_wr  = iocs && !iorw;
   assign rx_pop  = bus_rd && (ioaddr == 2'b00);
   assign tx_push = bus_wr && (ioaddr == 2'b00);
   assign div_wr  = bus_wr && ioaddr[1];

   spart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(tx_push), .push_dat_i(databus),
      .pop_i(tx_pop), .head_dat_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
   );

   spart_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(rx_push), .push_dat_i(rx_sh_q),
      .pop_i(rx_pop), .head_dat_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
   );

   assign tx_idle = (tx_state_q == ST_IDLE) && tx_empty;
   assign status  = {2'b00, tx_idle, tx_empty, rx_full, ovr_q, ferr_q, !rx_empty};
   assign rda     = !rx_empty;
   assign tbr     = !tx_full;
   assign txd     = txd_q;

   always_comb begin
      rd_dat = 8'h00;
      case (ioaddr)
         2'b00:   rd_dat = rx_empty ? 8'h00 : rx_head;
         2'b01:   rd_dat = status;
         2'b10:   rd_dat = div_q[7:0];
         default: rd_dat = div_q[15:8];
      endcase
   end

   assign databus = bus_rd ? rd_dat : 8'bz;

   always_comb begin
      div_d = div_q;
      if (bus_wr && ioaddr == 2'b10) div_d[7:0]  = databus;
      if (bus_wr && ioaddr == 2'b11) div_d[15:8] = databus;
   end

   // Counter sits at zero out of reset, so the first tick lands on the first clock.
   assign tick = (baud_cnt_q == 16'd0);
   always_comb begin
      if (div_wr)    baud_cnt_d = div_d;
      else if (tick) baud_cnt_d = div_q;
      else           baud_cnt_d = baud_cnt_q - 16'd1;
   end

   always_comb begin
      ferr_d = ferr_q;
      ovr_d  = ovr_q;
      if (bus_wr && ioaddr == 2'b01) begin
         if (databus[0]) ferr_d = 1'b0;
         if (databus[1]) ovr_d  = 1'b0;
      end
      if (rx_ferr_set) ferr_d = 1'b1;
      if (rx_ovr_set)  ovr_d  = 1'b1;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_tcnt_d  = tx_tcnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      txd_d      = 1'b1;
      if (tick) begin
         case (tx_state_q)
            ST_IDLE: begin
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_sh_d    = tx_head;
                  tx_tcnt_d  = '0;
                  tx_state_d = ST_START;
               end
            end
            ST_START: begin
               if (tx_tcnt_q == OS_LAST) begin
                  tx_tcnt_d  = '0;
                  tx_bit_d   = '0;
                  tx_state_d = ST_DATA;
               end else tx_tcnt_d = tx_tcnt_q + CW'(1);
            end
            ST_DATA: begin
               if (tx_tcnt_q == OS_LAST) begin
                  tx_tcnt_d = '0;
                  if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                  else begin
                     tx_bit_d = tx_bit_q + 3'd1;
                     tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  end
               end else tx_tcnt_d = tx_tcnt_q + CW'(1);
            end
            default: begin
               if (tx_tcnt_q == OS_LAST) begin
                  tx_tcnt_d = '0;
                  // Chain straight into the next start bit so queued frames leave gap-free.
                  if (!tx_empty) begin
                     tx_pop     = 1'b1;
                     tx_sh_d    = tx_head;
                     tx_state_d = ST_START;
                  end else tx_state_d = ST_IDLE;
               end else tx_tcnt_d = tx_tcnt_q + CW'(1);
            end
         endcase
      end
      case (tx_state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = tx_sh_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   assign rx_fall = rx_s3_q && !rx_s2_q;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_tcnt_d   = rx_tcnt_q;
      rx_bit_d    = rx_bit_q;
      rx_sh_d     = rx_sh_q;
      rx_push     = 1'b0;
      rx_ferr_set = 1'b0;
      rx_ovr_set  = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               rx_tcnt_d  = '0;
               rx_state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rx_tcnt_q == HALF_LAST) begin
                  rx_tcnt_d = '0;
                  rx_bit_d  = '0;
                  // A start bit that is high again at mid-bit was a glitch.
                  rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
               end else rx_tcnt_d = rx_tcnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (rx_tcnt_q == OS_LAST) begin
                  rx_tcnt_d = '0;
                  rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                  else rx_bit_d = rx_bit_q + 3'd1;
               end else rx_tcnt_d = rx_tcnt_q + CW'(1);
            end
         end
         default: begin
            if (tick) begin
               if (rx_tcnt_q == OS_LAST) begin
                  rx_tcnt_d  = '0;
                  rx_state_d = ST_IDLE;
                  if (!rx_s2_q) rx_ferr_set = 1'b1;
                  else begin
                     rx_push    = 1'b1;
                     rx_ovr_set = rx_full && !rx_pop;
                  end
               end else rx_tcnt_d = rx_tcnt_q + CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= RESET_DIV;
         baud_cnt_q <= 16'd0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         tx_state_q <= ST_IDLE;
         tx_tcnt_q  <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         txd_q      <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_tcnt_q  <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
      end else begin
         div_q      <= div_d;
         baud_cnt_q <= baud_cnt_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         tx_state_q <= tx_state_d;
         tx_tcnt_q  <= tx_tcnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_tcnt_q  <= rx_tcnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
      end
   end
endmodule

// File: tb/tb_spart_fifo.sv
`timescale 1ns/1ps
// Directed bench for spart_fifo: a queue-level model of the register map and FIFOs, checked per cycle and on bus reads.

module tb_spart_fifo;
   localparam int DEPTH = 8;
   localparam int OS    = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       iocs = 1'b0, iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic [7:0] tb_dat = 8'h00;
   logic       tb_oe = 1'b0;
   wire  [7:0] databus;
   logic       rda, tbr, txd, rxd;
   logic       rxd_drv = 1'b1, loop_en = 1'b0;

   assign rxd     = loop_en ? txd : rxd_drv;
   assign databus = tb_oe ? tb_dat : 8'bz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (databus[g]);
   end

   always #5 clk = ~clk;

   spart_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .RESET_DIV(16'd324)) dut (
      .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
      .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
   );

   logic [7:0]  m_rx[$];
   logic [7:0]  m_tx[$];
   logic        m_fe, m_ov;
   logic [15:0] m_div;
   int          checks = 0, errors = 0;
   logic        chk_en = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic void m_reset();
      m_rx.delete();
      m_tx.delete();
      m_fe  = 1'b0;
      m_ov  = 1'b0;
      m_div = 16'd324;
   endfunction

   function automatic void m_frame(input logic [7:0] d, input logic stop);
      if (!stop) m_fe = 1'b1;
      else if (m_rx.size() >= DEPTH) m_ov = 1'b1;
      else m_rx.push_back(d);
   endfunction

   function automatic logic [7:0] m_status();
      return {2'b00, m_tx.size() == 0, m_tx.size() == 0, m_rx.size() == DEPTH, m_ov, m_fe, m_rx.size() != 0};
   endfunction

   function automatic logic [7:0] m_read(input logic [1:0] a);
      case (a)
         2'b00:   return (m_rx.size() == 0) ? 8'h00 : m_rx.pop_front();
         2'b01:   return m_status();
         2'b10:   return m_div[7:0];
         default: return m_div[15:8];
      endcase
   endfunction

   function automatic void m_write(input logic [1:0] a, input logic [7:0] d);
      case (a)
         2'b00: if (m_tx.size() < DEPTH) m_tx.push_back(d);
         2'b01: begin
            if (d[0]) m_fe = 1'b0;
            if (d[1]) m_ov = 1'b0;
         end
         2'b10:   m_div[7:0]  = d;
         default: m_div[15:8] = d;
      endcase
   endfunction

   // Everything queued for transmit has gone out; in loopback it arrives at the receiver.
   function automatic void m_deliver(input logic looped);
      logic [7:0] b;
      while (m_tx.size() > 0) begin
         b = m_tx.pop_front();
         if (looped) m_frame(b, 1'b1);
      end
   endfunction

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_oe = 1'b1;
      #1 m_write(a, d);
      @(negedge clk);
      iocs = 1'b0; tb_oe = 1'b0;
   endtask

   task automatic bus_rd(input string name, input logic [1:0] a, output logic [7:0] v);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a; tb_oe = 1'b0;
      #1 v = databus;
      chk(name, v, m_read(a));
      @(negedge clk);
      iocs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      int bp;
      bp = OS * (int'(m_div) + 1);
      rxd_drv = 1'b0;
      idle(bp);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = d[i];
         idle(bp);
      end
      rxd_drv = stop;
      idle(bp);
      rxd_drv = 1'b1;
      idle(bp);
      m_frame(d, stop);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_rda", {7'd0, rda}, {7'd0, m_rx.size() != 0});
         chk("cyc_tbr", {7'd0, tbr}, {7'd0, m_tx.size() < DEPTH});
         chk("cyc_txd_idle", {7'd0, txd}, 8'h01);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      int n;
      m_reset();
      idle(3);
      chk("rst_txd", {7'd0, txd}, 8'h01);
      chk("rst_rda", {7'd0, rda}, 8'h00);
      chk("rst_tbr", {7'd0, tbr}, 8'h01);
      rst_n = 1'b1;
      @(negedge clk);
      ioaddr = 2'b10;
      #1 chk("rst_bus_released", databus, 8'hFF);
      @(negedge clk);
      chk_en = 1'b1;
      bus_rd("rst_div_lo", 2'b10, v);  chk("rst_div_lo_lit", v, 8'h44);
      bus_rd("rst_div_hi", 2'b11, v);  chk("rst_div_hi_lit", v, 8'h01);
      bus_rd("rst_status", 2'b01, v);  chk("rst_status_lit", v, 8'h30);
      bus_rd("rst_rx_empty", 2'b00, v); chk("rst_rx_empty_lit", v, 8'h00);

      // Loopback at DIV=0: one frame is 160 clocks.
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'h00);
      loop_en = 1'b1;
      chk_en  = 1'b0;
      bus_wr(2'b00, 8'hA5);
      n = 0;
      while (!rda && n < 160) begin
         @(negedge clk);
         n++;
      end
      chk("lb_rda_within_frame", {7'd0, rda}, 8'h01);
      idle(20);
      m_deliver(1'b1);
      chk_en = 1'b1;
      bus_rd("lb_data", 2'b00, v);  chk("lb_data_lit", v, 8'hA5);
      idle(2);
      chk("lb_rda_after_pop", {7'd0, rda}, 8'h00);

      // TX full: divisor reload holds off the first tick until all nine writes are in.
      bus_wr(2'b11, 8'h00);
      bus_wr(2'b10, 8'h0F);
      for (int i = 1; i <= 9; i++) bus_wr(2'b00, 8'(i));
      chk("txfull_tbr", {7'd0, tbr}, 8'h00);
      chk_en = 1'b0;
      idle(8 * 10 * OS * 16 + 600);
      m_deliver(1'b1);
      chk_en = 1'b1;
      bus_rd("txfull_status", 2'b01, v);  chk("txfull_status_lit", v, 8'h39);
      for (int i = 0; i < 8; i++) begin
         bus_rd("txfull_rx", 2'b00, v);
         if (i == 0) chk("txfull_first_lit", v, 8'h01);
         if (i == 7) chk("txfull_last_lit", v, 8'h08);
      end
      bus_rd("txfull_drained", 2'b01, v);  chk("txfull_drained_lit", v, 8'h30);

      // Overrun: nine externally driven frames, no reads.
      bus_wr(2'b10, 8'h00);
      loop_en = 1'b0;
      chk_en  = 1'b0;
      for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b1);
      chk_en = 1'b1;
      bus_rd("ovr_status", 2'b01, v);  chk("ovr_status_lit", v, 8'h3D);
      bus_wr(2'b01, 8'h02);
      bus_rd("ovr_cleared", 2'b01, v);  chk("ovr_cleared_lit", v, 8'h39);
      for (int i = 0; i < 8; i++) begin
         bus_rd("ovr_rx", 2'b00, v);
         if (i == 0) chk("ovr_first_lit", v, 8'h10);
         if (i == 7) chk("ovr_last_lit", v, 8'h17);
      end

      // Framing error: stop bit driven low.
      chk_en = 1'b0;
      send_frame(8'h5A, 1'b0);
      chk_en = 1'b1;
      bus_rd("ferr_status", 2'b01, v);  chk("ferr_status_lit", v, 8'h32);
      bus_wr(2'b01, 8'h01);
      bus_rd("ferr_cleared", 2'b01, v);  chk("ferr_cleared_lit", v, 8'h30);

      // Glitch shorter than half a bit.
      rxd_drv = 1'b0;
      idle(3);
      rxd_drv = 1'b1;
      idle(40);
      bus_rd("glitch_status", 2'b01, v);  chk("glitch_status_lit", v, 8'h30);

      // Reset in the middle of a frame with a second byte still queued.
      chk_en = 1'b0;
      bus_wr(2'b00, 8'h3C);
      bus_wr(2'b00, 8'hC3);
      idle(40);
      rst_n = 1'b0;
      #1;
      chk("midrst_txd", {7'd0, txd}, 8'h01);
      chk("midrst_tbr", {7'd0, tbr}, 8'h01);
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      bus_rd("midrst_status", 2'b01, v);  chk("midrst_status_lit", v, 8'h30);
      bus_rd("midrst_div_lo", 2'b10, v);
      idle(300);
      chk_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
